// File: rtl/data_memory_pkg.sv
// Shared widths, FSM state encoding and port identifiers for the data memory arbiter.
package data_memory_pkg;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin tie-break: on contention the port that did not win last gets the grant.
module rr_arbiter_2
  import data_memory_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      rr_last,
  output logic [1:0] gnt
);
  // bit 0 = port A, bit 1 = port B
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr_last == PORT_B) ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one data memory between the core LSU (port A) and the DMA engine (port B):
// same-cycle grants, round-robin with bounded bursts, registered read return.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_read_adr,
  output logic [ADDR_W-1:0] mem_write_adr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out
);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t           state, state_nx;
  logic [CNT_W-1:0] beat_cnt, beat_nx;
  port_t            rr_last;
  logic [1:0]       tie_gnt;
  logic             win_a, win_b, burst_ok;

  rr_arbiter_2 u_tie (
    .req     ({b_req, a_req}),
    .rr_last (rr_last),
    .gnt     (tie_gnt)
  );

  assign burst_ok = (beat_cnt < MAX_CNT);

  // Owner keeps the grant until its burst is spent, then yields only if the other side waits.
  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    unique case (state)
      ST_OWN_A: begin
        if (a_req && burst_ok) win_a = 1'b1;
        else if (b_req)        win_b = 1'b1;
        else if (a_req)        win_a = 1'b1;
      end
      ST_OWN_B: begin
        if (b_req && burst_ok) win_b = 1'b1;
        else if (a_req)        win_a = 1'b1;
        else if (b_req)        win_b = 1'b1;
      end
      default: {win_b, win_a} = tie_gnt;
    endcase
  end

  always_comb begin
    state_nx = ST_IDLE;
    beat_nx  = '0;
    if (win_a) begin
      state_nx = ST_OWN_A;
      beat_nx  = (state == ST_OWN_A && burst_ok) ? beat_cnt + 1'b1 : CNT_W'(1);
    end else if (win_b) begin
      state_nx = ST_OWN_B;
      beat_nx  = (state == ST_OWN_B && burst_ok) ? beat_cnt + 1'b1 : CNT_W'(1);
    end
  end

  assign a_gnt = win_a & rst_n;
  assign b_gnt = win_b & rst_n;

  always_comb begin
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_read_adr  = '0;
    mem_write_adr = '0;
    mem_data_in   = '0;
    if (a_gnt) begin
      if (a_we) begin
        mem_wr        = 1'b1;
        mem_write_adr = a_adr;
        mem_data_in   = a_wdata;
      end else begin
        mem_rd       = 1'b1;
        mem_read_adr = a_adr;
      end
    end else if (b_gnt) begin
      if (b_we) begin
        mem_wr        = 1'b1;
        mem_write_adr = b_adr;
        mem_data_in   = b_wdata;
      end else begin
        mem_rd       = 1'b1;
        mem_read_adr = b_adr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      rr_last  <= PORT_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_nx;
      if (win_a)      rr_last <= PORT_A;
      else if (win_b) rr_last <= PORT_B;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata <= mem_data_out;
      if (b_gnt && !b_we) b_rdata <= mem_data_out;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural memory and a read-data scoreboard.
module tb_data_memory_arbiter;
  import data_memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_adr, b_adr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [63:0] a_rdata, b_rdata;
  logic [63:0] mem_data_in, mem_data_out;
  logic [9:0]  mem_read_adr, mem_write_adr;
  logic        mem_rd, mem_wr;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [63:0] mem_model [0:1023];
  logic [63:0] ref_mem [int unsigned];
  logic [63:0] a_exp_q[$];
  logic [63:0] b_exp_q[$];

  always #5 clk = ~clk;

  data_memory_arbiter #(.DATA_W(64), .ADDR_W(10), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_data_in(mem_data_in), .mem_read_adr(mem_read_adr),
    .mem_write_adr(mem_write_adr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out)
  );

  assign mem_data_out = mem_model[mem_read_adr];
  always @(posedge clk) if (mem_wr) mem_model[mem_write_adr] <= mem_data_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (a_rvalid) begin
      if (a_exp_q.size() == 0) chk("a_rvalid_unexpected", 64'(a_rvalid), 64'd0);
      else chk("a_rdata", a_rdata, a_exp_q.pop_front());
    end
    if (b_rvalid) begin
      if (b_exp_q.size() == 0) chk("b_rvalid_unexpected", 64'(b_rvalid), 64'd0);
      else chk("b_rdata", b_rdata, b_exp_q.pop_front());
    end
  end

  task automatic drive(input logic ar, input logic aw, input logic [9:0] aa, input logic [63:0] ad,
                       input logic br, input logic bw, input logic [9:0] ba, input logic [63:0] bd);
    a_req = ar; a_we = aw; a_adr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_adr = ba; b_wdata = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h002, '0);

    // reset with both requests asserted
    next_cycle();
    @(negedge clk);
    chk("rst_a_gnt", 64'(a_gnt), 64'd0);
    chk("rst_b_gnt", 64'(b_gnt), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_b_rvalid", 64'(b_rvalid), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("idle_read_adr", 64'(mem_read_adr), 64'd0);
    chk("idle_mem_rd", 64'(mem_rd), 64'd0);

    // single write then read by A
    next_cycle();
    drive(1'b1, 1'b1, 10'h184, 64'h0502_0000_80E0_0000, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wr_a_gnt", 64'(a_gnt), 64'd1);
    chk("wr_mem_wr", 64'(mem_wr), 64'd1);
    chk("wr_mem_write_adr", 64'(mem_write_adr), 64'h184);
    chk("wr_mem_data_in", mem_data_in, 64'h0502_0000_80E0_0000);
    chk("wr_mem_rd", 64'(mem_rd), 64'd0);
    ref_mem[10'h184] = 64'h0502_0000_80E0_0000;
    next_cycle();
    drive(1'b1, 1'b0, 10'h184, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rd_a_gnt", 64'(a_gnt), 64'd1);
    chk("rd_mem_rd", 64'(mem_rd), 64'd1);
    chk("rd_mem_read_adr", 64'(mem_read_adr), 64'h184);
    chk("rd_mem_data_in_zero", mem_data_in, 64'd0);
    a_exp_q.push_back(ref_mem[10'h184]);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("rd_a_rvalid", 64'(a_rvalid), 64'd1);
    next_cycle();
    chk("rd_a_rvalid_pulse", 64'(a_rvalid), 64'd0);

    // contention from reset: A first, bursts of four
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 10'(10'h010 + i), 64'(64'hA000 + i),
            1'b1, 1'b1, 10'(10'h020 + i), 64'(64'hB000 + i));
      @(negedge clk);
      if (i < 4 || i == 8) begin
        chk($sformatf("tie_a_gnt[%0d]", i), 64'(a_gnt), 64'd1);
        chk($sformatf("tie_b_gnt[%0d]", i), 64'(b_gnt), 64'd0);
        chk($sformatf("tie_wadr[%0d]", i), 64'(mem_write_adr), 64'(10'h010 + i));
      end else begin
        chk($sformatf("tie_a_gnt[%0d]", i), 64'(a_gnt), 64'd0);
        chk($sformatf("tie_b_gnt[%0d]", i), 64'(b_gnt), 64'd1);
        chk($sformatf("tie_wadr[%0d]", i), 64'(mem_write_adr), 64'(10'h020 + i));
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();

    // A alone for six cycles: burst restarts without a gap, back-to-back reads
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 10'h184, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk($sformatf("solo_a_gnt[%0d]", i), 64'(a_gnt), 64'd1);
      chk($sformatf("solo_b_gnt[%0d]", i), 64'(b_gnt), 64'd0);
      a_exp_q.push_back(ref_mem[10'h184]);
      next_cycle();
      if (i > 0) chk($sformatf("solo_rvalid[%0d]", i), 64'(a_rvalid), 64'd1);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();

    // B writes, A reads the same word on the next grant
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h1A4, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    chk("raw_b_gnt", 64'(b_gnt), 64'd1);
    chk("raw_b_wadr", 64'(mem_write_adr), 64'h1A4);
    ref_mem[10'h1A4] = 64'h0000_0000_DEAD_BEEF;
    next_cycle();
    drive(1'b1, 1'b0, 10'h1A4, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("raw_a_gnt", 64'(a_gnt), 64'd1);
    a_exp_q.push_back(ref_mem[10'h1A4]);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("raw_b_rvalid", 64'(b_rvalid), 64'd0);
    next_cycle();

    // reset lands while a granted read is still in flight
    drive(1'b1, 1'b0, 10'h184, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("mid_a_gnt", 64'(a_gnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_gnt_forced", 64'(a_gnt), 64'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    chk("mid_a_rvalid", 64'(a_rvalid), 64'd0);
    chk("mid_state", 64'(dut.state), 64'(ST_IDLE));
    rst_n = 1'b1;
    next_cycle();
    chk("mid_a_rvalid_after", 64'(a_rvalid), 64'd0);

    chk("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
    chk("b_queue_drained", 64'(b_exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
